// File: rtl/soft_pll_pkg.sv
// Shared types and default constants for the soft PLL stand-in.
`timescale 1ns/1ps
package soft_pll_pkg;

  typedef enum logic {
    MEASURE = 1'b0,
    LOCKED  = 1'b1
  } pll_state_t;

  localparam int DEF_CLKIN_PERIOD = 10;
  localparam int DEF_PERIOD_TOL   = 1;
  localparam int DEF_LOCK_CNT     = 8;
  localparam int DEF_UNLOCK_CNT   = 4;
  localparam int DEF_OUT0_HALF    = 2;
  localparam int DEF_OUT1_HALF    = 5;
  localparam int DEF_CNT_W        = 16;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/soft_pll_odiv.sv
// Fixed integer clock divider: toggles its output every HALF clk_tb cycles,
// held low with its counter at zero while i_clr is high.
`timescale 1ns/1ps
module soft_pll_odiv
  import soft_pll_pkg::*;
#(
  parameter int HALF  = DEF_OUT0_HALF,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk_tb,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_clk
);

  localparam logic [CNT_W-1:0] TC_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else if (r_cnt == TC_M1) begin
      r_cnt <= '0;
      r_clk <= ~r_clk;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_clk = r_clk;

endmodule

// File: rtl/soft_pll_core.sv
// Digital PLL stand-in: qualifies clkin1/clkfb periods against clk_tb,
// drives fixed-ratio output clocks and a glitch-free lock indicator.
//
//   state   | meaning
//   MEASURE | counting consecutive good reference periods towards lock
//   LOCKED  | pll_lock high, counting consecutive bad periods towards unlock
`timescale 1ns/1ps
module soft_pll_core
  import soft_pll_pkg::*;
#(
  parameter int CLKIN_PERIOD = DEF_CLKIN_PERIOD,
  parameter int PERIOD_TOL   = DEF_PERIOD_TOL,
  parameter int LOCK_CNT     = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT   = DEF_UNLOCK_CNT,
  parameter int OUT0_HALF    = DEF_OUT0_HALF,
  parameter int OUT1_HALF    = DEF_OUT1_HALF,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk_tb,
  input  logic rst_n,
  input  logic clkin1,
  input  logic clkfb,
  input  logic pll_rst,
  output logic clkout0,
  output logic clkout1,
  output logic pll_lock
);

  localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(2 * CLKIN_PERIOD);
  localparam logic [CNT_W-1:0] PER_LO    = CNT_W'(CLKIN_PERIOD - PERIOD_TOL);
  localparam logic [CNT_W-1:0] PER_HI    = CNT_W'(CLKIN_PERIOD + PERIOD_TOL);
  localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] UNLOCK_TC = CNT_W'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [SYNC_DEPTH-1:0] r_in_sync, r_fb_sync, r_rst_sync;
  logic                  r_in_d, r_fb_d;
  logic                  w_in_edge, w_fb_edge, w_clr;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      r_in_sync  <= '0;
      r_fb_sync  <= '0;
      r_rst_sync <= '0;
      r_in_d     <= 1'b0;
      r_fb_d     <= 1'b0;
    end else begin
      r_in_sync  <= {r_in_sync[SYNC_DEPTH-2:0], clkin1};
      r_fb_sync  <= {r_fb_sync[SYNC_DEPTH-2:0], clkfb};
      r_rst_sync <= {r_rst_sync[SYNC_DEPTH-2:0], pll_rst};
      r_in_d     <= r_in_sync[SYNC_DEPTH-1];
      r_fb_d     <= r_fb_sync[SYNC_DEPTH-1];
    end
  end

  assign w_in_edge = r_in_sync[SYNC_DEPTH-1] & ~r_in_d;
  assign w_fb_edge = r_fb_sync[SYNC_DEPTH-1] & ~r_fb_d;
  assign w_clr     = r_rst_sync[SYNC_DEPTH-1];

  logic [CNT_W-1:0] r_cnt_in;
  logic             r_armed, r_fb_seen;
  logic             w_eval, w_timeout, w_in_tol, w_good, w_bad;

  assign w_eval    = w_in_edge & r_armed;
  assign w_timeout = (r_cnt_in == TIMEOUT) & ~w_in_edge;
  assign w_in_tol  = (r_cnt_in >= PER_LO) && (r_cnt_in <= PER_HI);
  assign w_good    = w_eval & w_in_tol & r_fb_seen;
  assign w_bad     = (w_eval & ~w_good) | w_timeout;

  // An fb edge coinciding with an evaluation belongs to the next period.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_in  <= '0;
      r_armed   <= 1'b0;
      r_fb_seen <= 1'b0;
    end else if (w_clr) begin
      r_cnt_in  <= '0;
      r_armed   <= 1'b0;
      r_fb_seen <= 1'b0;
    end else begin
      if (w_in_edge)              r_cnt_in <= ONE;
      else if (w_timeout)         r_cnt_in <= '0;
      else if (r_cnt_in != TIMEOUT) r_cnt_in <= r_cnt_in + ONE;
      if (w_in_edge) r_armed <= 1'b1;
      if (w_eval)         r_fb_seen <= w_fb_edge;
      else if (w_fb_edge) r_fb_seen <= 1'b1;
    end
  end

  pll_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_good_cnt, w_good_nxt, r_bad_cnt, w_bad_nxt;
  logic             r_lock;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_bad_cnt;
    case (r_state)
      MEASURE: begin
        if (w_good) begin
          w_good_nxt = (r_good_cnt == '1) ? r_good_cnt : r_good_cnt + ONE;
          if (w_good_nxt >= LOCK_TC) begin
            w_state_nxt = LOCKED;
            w_bad_nxt   = '0;
          end
        end else if (w_bad) begin
          w_good_nxt = '0;
        end
      end
      LOCKED: begin
        if (w_good) begin
          w_bad_nxt = '0;
        end else if (w_bad) begin
          w_bad_nxt = (r_bad_cnt == '1) ? r_bad_cnt : r_bad_cnt + ONE;
          if (w_bad_nxt >= UNLOCK_TC) begin
            w_state_nxt = MEASURE;
            w_good_nxt  = '0;
          end
        end
      end
      default: w_state_nxt = MEASURE;
    endcase
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= MEASURE;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_lock     <= 1'b0;
    end else if (w_clr) begin
      r_state    <= MEASURE;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_lock     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_bad_cnt  <= w_bad_nxt;
      r_lock     <= (w_state_nxt == LOCKED);
    end
  end

  assign pll_lock = r_lock;

  // Dividers free-run regardless of lock since clkfb is derived from clkout0.
  soft_pll_odiv #(.HALF(OUT0_HALF), .CNT_W(CNT_W)) u_odiv0 (
    .clk_tb (clk_tb),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .o_clk  (clkout0)
  );

  soft_pll_odiv #(.HALF(OUT1_HALF), .CNT_W(CNT_W)) u_odiv1 (
    .clk_tb (clk_tb),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .o_clk  (clkout1)
  );

endmodule

// File: tb/tb_soft_pll_core.sv
// Self-checking bench for soft_pll_core: vector table, corner sequences and
// randomized reference timing checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_soft_pll_core;

  localparam int P     = 10;
  localparam int TOL   = 1;
  localparam int LOCKN = 8;
  localparam int ULKN  = 4;
  localparam int H0    = 2;
  localparam int H1    = 5;

  logic clk_tb = 1'b0;
  logic rst_n, clkin1, pll_rst;
  logic clkout0, clkout1, pll_lock;
  logic clkfb;
  bit   fb_tied;

  int checks = 0;
  int errors = 0;

  assign clkfb = fb_tied ? 1'b0 : clkout0;

  always #1 clk_tb = ~clk_tb;

  soft_pll_core dut (
    .clk_tb   (clk_tb),
    .rst_n    (rst_n),
    .clkin1   (clkin1),
    .clkfb    (clkfb),
    .pll_rst  (pll_rst),
    .clkout0  (clkout0),
    .clkout1  (clkout1),
    .pll_lock (pll_lock)
  );

  // Reference model: inputs are sampled once per clk_tb edge; an input rise
  // is acted on two edges after it is first sampled high; a period is the
  // number of clk_tb edges between acted-on rises.
  int   n = 0, ref_c = 0, good_c = 0, bad_c = 0, k_div = 0;
  bit   armed = 0, fb_seen = 0, locked = 0;
  bit   e_lock = 0, e_o0 = 0, e_o1 = 0;
  logic [3:0] in_h = '0, fb_h = '0, rs_h = '0;
  int   lock_rises = 0;
  logic lock_prev = 1'b0;

  always @(negedge clk_tb) begin
    bit rise_in, rise_fb, good, bad;
    int per;
    checks++;
    if (pll_lock !== e_lock || clkout0 !== e_o0 || clkout1 !== e_o1) begin
      errors++;
      if (errors <= 20)
        $display("FAIL model_cycle %0d actual lock/o1/o0=%b%b%b required=%b%b%b",
                 n, pll_lock, clkout1, clkout0, e_lock, e_o1, e_o0);
    end
    if (pll_lock === 1'b1 && lock_prev !== 1'b1) lock_rises++;
    lock_prev = pll_lock;

    n++;
    in_h = {in_h[2:0], rst_n ? clkin1 : 1'b0};
    fb_h = {fb_h[2:0], rst_n ? clkfb : 1'b0};
    rs_h = {rs_h[2:0], rst_n ? pll_rst : 1'b0};
    if (!rst_n || rs_h[2]) begin
      ref_c = n + 1; armed = 0; fb_seen = 0;
      good_c = 0; bad_c = 0; locked = 0; k_div = 0;
    end else begin
      k_div++;
      rise_in = in_h[2] & ~in_h[3];
      rise_fb = fb_h[2] & ~fb_h[3];
      per = n - ref_c;
      good = 0; bad = 0;
      if (rise_in) begin
        if (armed) begin
          good = (per >= P - TOL) && (per <= P + TOL) && fb_seen;
          bad = !good;
          fb_seen = rise_fb;
        end else begin
          armed = 1;
          if (rise_fb) fb_seen = 1;
        end
        ref_c = n;
      end else begin
        if (rise_fb) fb_seen = 1;
        if (per == 2 * P) begin bad = 1; ref_c = n + 1; end
      end
      if (!locked) begin
        if (good) begin
          good_c++;
          if (good_c >= LOCKN) begin locked = 1; bad_c = 0; end
        end else if (bad) good_c = 0;
      end else begin
        if (good) bad_c = 0;
        else if (bad) begin
          bad_c++;
          if (bad_c >= ULKN) begin locked = 0; good_c = 0; end
        end
      end
    end
    e_lock = locked;
    e_o0 = ((k_div / H0) % 2) == 1;
    e_o1 = ((k_div / H1) % 2) == 1;
  end

  task automatic cyc(input int c);
    repeat (c) begin @(posedge clk_tb); #0.3; end
  endtask

  task automatic clk_period(input int hi, input int lo);
    clkin1 = 1'b1; cyc(hi);
    clkin1 = 1'b0; cyc(lo);
  endtask

  task automatic pll_reset(input int c);
    pll_rst = 1'b1; cyc(c); pll_rst = 1'b0;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int hi;
    int lo;
    bit fb0;
    int nper;
    int exp_lock;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{5, 5, 1'b0, 15, 1};
    vecs[1] = '{5, 6, 1'b0, 15, 1};
    vecs[2] = '{4, 5, 1'b0, 15, 1};
    vecs[3] = '{6, 6, 1'b0, 20, 0};
    vecs[4] = '{4, 4, 1'b0, 20, 0};
    vecs[5] = '{5, 5, 1'b1, 20, 0};

    rst_n = 1'b0; clkin1 = 1'b0; pll_rst = 1'b0; fb_tied = 1'b0;
    @(posedge clk_tb); #0.3;
    cyc(9);
    check("rst_lock", int'(pll_lock), 0);
    check("rst_clkout0", int'(clkout0), 0);
    check("rst_clkout1", int'(clkout1), 0);
    rst_n = 1'b1;
    cyc(9);
    pll_reset(10);
    cyc(4);

    for (int i = 0; i < 6; i++) begin
      fb_tied = vecs[i].fb0;
      pll_reset(3);
      lock_rises = 0;
      repeat (vecs[i].nper) clk_period(vecs[i].hi, vecs[i].lo);
      check($sformatf("vec%0d_lock", i), int'(pll_lock), vecs[i].exp_lock);
      check($sformatf("vec%0d_rises", i), lock_rises, vecs[i].exp_lock);
    end

    // Isolated bad periods must not break lock; a good one resets the tally.
    fb_tied = 1'b0;
    pll_reset(3);
    repeat (15) clk_period(5, 5);
    check("seq_locked", int'(pll_lock), 1);
    clk_period(7, 7);
    repeat (3) clk_period(5, 5);
    check("single_bad_hold", int'(pll_lock), 1);
    repeat (3) clk_period(7, 7);
    clk_period(5, 5);
    repeat (3) clk_period(7, 7);
    clk_period(5, 5);
    check("bad_cnt_cleared", int'(pll_lock), 1);
    repeat (4) clk_period(7, 7);
    clk_period(5, 5);
    check("unlock_4bad", int'(pll_lock), 0);

    // Reference loss: timeouts drop lock, restart relocks.
    repeat (15) clk_period(5, 5);
    check("relock_before_stop", int'(pll_lock), 1);
    clkin1 = 1'b0;
    cyc(100);
    check("timeout_unlock", int'(pll_lock), 0);
    repeat (12) clk_period(5, 5);
    check("relock_after_restart", int'(pll_lock), 1);

    // pll_rst while locked, then divider restart phase.
    pll_rst = 1'b1;
    cyc(3);
    check("prst_lock", int'(pll_lock), 0);
    check("prst_clkout0", int'(clkout0), 0);
    check("prst_clkout1", int'(clkout1), 0);
    cyc(2);
    pll_rst = 1'b0;
    cyc(3);
    check("odiv_pre_rise", int'(clkout0), 0);
    cyc(1);
    check("odiv_first_rise", int'(clkout0), 1);

    // Randomized reference timing, gaps, feedback loss and pll_rst pulses.
    for (int i = 0; i < 180; i++) begin
      int hi, lo;
      hi = $urandom_range(3, 7);
      lo = ($urandom_range(0, 14) == 0) ? $urandom_range(15, 45) : $urandom_range(4, 6);
      if ($urandom_range(0, 29) == 0) fb_tied = ~fb_tied;
      if ($urandom_range(0, 39) == 0) pll_reset($urandom_range(1, 4));
      clk_period(hi, lo);
    end
    fb_tied = 1'b0;
    repeat (12) clk_period(5, 5);
    check("rand_final_lock", int'(pll_lock), 1);

    cyc(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
